// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the program-counter sequencer and the PC register.
package pc_sequencer_pkg;

    // Address width shared with the PC register (PC3 and PC8 concatenated)
    localparam int PC_ADDR_W = 11;

    typedef logic [2:0] op_t;
    typedef logic [1:0] err_t;
    typedef logic [1:0] state_t;

    // Next-address operations
    localparam op_t OP_SEQ    = 3'd0;
    localparam op_t OP_BRANCH = 3'd1;
    localparam op_t OP_JUMP   = 3'd2;
    localparam op_t OP_CALL   = 3'd3;
    localparam op_t OP_RET    = 3'd4;
    localparam op_t OP_HALT   = 3'd5;

    // Fault causes
    localparam err_t ERR_NONE = 2'd0;
    localparam err_t ERR_OVF  = 2'd1;
    localparam err_t ERR_UDF  = 2'd2;
    localparam err_t ERR_ILL  = 2'd3;

    // Sequencer states
    localparam state_t ST_RUN   = 2'd0;
    localparam state_t ST_HALT  = 2'd1;
    localparam state_t ST_FAULT = 2'd2;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control and status bundle between the instruction decoder and the sequencer.
interface pc_sequencer_if #(
    parameter int ADDR_W      = pc_sequencer_pkg::PC_ADDR_W,
    parameter int STACK_DEPTH = 4
);
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;

    logic              en;
    logic [2:0]        op;
    logic              cond;
    logic [ADDR_W-1:0] target;
    logic              resume;
    logic [ADDR_W-1:0] pc_out;
    logic              halted;
    logic              fault;
    logic [1:0]        err;
    logic [SP_W-1:0]   depth;

    modport master (
        output en, op, cond, target, resume,
        input  pc_out, halted, fault, err, depth
    );

    modport slave (
        input  en, op, cond, target, resume,
        output pc_out, halted, fault, err, depth
    );

endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO. Only the pointer is reset; contents are don't-care.
module ret_stack #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   sp
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int SP_W  = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [SP_W-1:0]  sp_q, sp_d;
    logic [PTR_W-1:0] wr_idx, rd_idx;

    assign full   = (sp_q == SP_W'(DEPTH));
    assign empty  = (sp_q == '0);
    assign wr_idx = PTR_W'(sp_q);
    assign rd_idx = PTR_W'(sp_q - SP_W'(1));
    assign dout   = mem_q[rd_idx];
    assign sp     = sp_q;

    // Pointer update; push onto a full stack or pop from an empty one is ignored
    always_comb begin
        sp_d = sp_q;
        if (push && !full)
            sp_d = sp_q + SP_W'(1);
        else if (pop && !empty)
            sp_d = sp_q - SP_W'(1);
    end

    // Stack pointer register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            sp_q <= '0;
        else
            sp_q <= sp_d;
    end

    // Entry storage, written at the current top on push
    always_ff @(posedge CLK) begin
        if (push && !full)
            mem_q[wr_idx] <= din;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-address controller for the program counter, with return stack and
// halt/fault status. pc_out is registered so it settles before the PC
// register's falling-edge write.
module pc_sequencer import pc_sequencer_pkg::*; #(
    parameter int                ADDR_W       = PC_ADDR_W,
    parameter int                STACK_DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic         CLK,
    input  logic         RST_N,
    pc_sequencer_if.slave bus
);
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    err_t              err_q, err_d;
    logic [ADDR_W-1:0] pc_inc;
    logic              push, pop;
    logic [ADDR_W-1:0] stk_dout;
    logic              stk_full, stk_empty;
    logic [SP_W-1:0]   stk_sp;

    assign pc_inc = pc_q + ADDR_W'(1);

    ret_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty),
        .sp    (stk_sp)
    );

    // Next-state, next-address and stack control; all fault decisions live here
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        push    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.en) begin
                    case (bus.op)
                        OP_SEQ:    pc_d = pc_inc;
                        OP_BRANCH: pc_d = bus.cond ? bus.target : pc_inc;
                        OP_JUMP:   pc_d = bus.target;
                        OP_CALL: begin
                            if (stk_full) begin
                                state_d = ST_FAULT;
                                err_d   = ERR_OVF;
                            end else begin
                                push = 1'b1;
                                pc_d = bus.target;
                            end
                        end
                        OP_RET: begin
                            if (stk_empty) begin
                                state_d = ST_FAULT;
                                err_d   = ERR_UDF;
                            end else begin
                                pop  = 1'b1;
                                pc_d = stk_dout;
                            end
                        end
                        OP_HALT:   state_d = ST_HALT;
                        default: begin
                            state_d = ST_FAULT;
                            err_d   = ERR_ILL;
                        end
                    endcase
                end
            end
            ST_HALT: begin
                // resume takes priority; en/op are not looked at while halted
                if (bus.resume) begin
                    state_d = ST_RUN;
                    pc_d    = pc_inc;
                end
            end
            default: begin
                // FAULT is sticky until reset
                state_d = state_q;
            end
        endcase
    end

    // State, address and fault-cause registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_VECTOR;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

    assign bus.pc_out = pc_q;
    assign bus.halted = (state_q == ST_HALT);
    assign bus.fault  = (state_q == ST_FAULT);
    assign bus.err    = err_q;
    assign bus.depth  = stk_sp;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: hand-computed expected values per step.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic CLK;
    logic RST_N;
    int   total;
    int   bad;

    pc_sequencer_if #(.ADDR_W(11), .STACK_DEPTH(4)) bus ();

    pc_sequencer #(
        .ADDR_W       (11),
        .STACK_DEPTH  (4),
        .RESET_VECTOR (11'h000)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [10:0] e_pc, input logic e_h,
                       input logic e_f, input logic [1:0] e_err, input logic [2:0] e_dep);
        total++;
        assert (bus.pc_out === e_pc) else begin
            bad++;
            $error("FAIL %s pc_out observed=%h expected=%h", tag, bus.pc_out, e_pc);
        end
        total++;
        assert (bus.halted === e_h) else begin
            bad++;
            $error("FAIL %s halted observed=%b expected=%b", tag, bus.halted, e_h);
        end
        total++;
        assert (bus.fault === e_f) else begin
            bad++;
            $error("FAIL %s fault observed=%b expected=%b", tag, bus.fault, e_f);
        end
        total++;
        assert (bus.err === e_err) else begin
            bad++;
            $error("FAIL %s err observed=%0d expected=%0d", tag, bus.err, e_err);
        end
        total++;
        assert (bus.depth === e_dep) else begin
            bad++;
            $error("FAIL %s depth observed=%0d expected=%0d", tag, bus.depth, e_dep);
        end
    endtask

    // Drive one step's inputs, let one rising edge pass, sample 1 ns later
    task automatic step(input logic e, input logic [2:0] o, input logic c,
                        input logic [10:0] t, input logic r);
        bus.en     = e;
        bus.op     = o;
        bus.cond   = c;
        bus.target = t;
        bus.resume = r;
        @(posedge CLK);
        #1;
    endtask

    // Asynchronous reset mid-cycle, checked before any clock edge, then released
    task automatic async_reset(input string tag);
        bus.en     = 1'b0;
        bus.resume = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        chk(tag, 11'h000, 1'b0, 1'b0, ERR_NONE, 3'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        RST_N      = 1'b0;
        bus.en     = 1'b0;
        bus.op     = OP_SEQ;
        bus.cond   = 1'b0;
        bus.target = '0;
        bus.resume = 1'b0;
        #12;
        chk("reset", 11'h000, 1'b0, 1'b0, ERR_NONE, 3'd0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("post_reset_idle", 11'h000, 1'b0, 1'b0, ERR_NONE, 3'd0);

        step(1'b1, OP_SEQ, 1'b0, 11'h000, 1'b0);
        chk("seq1", 11'h001, 1'b0, 1'b0, ERR_NONE, 3'd0);
        step(1'b1, OP_SEQ, 1'b0, 11'h000, 1'b0);
        chk("seq2", 11'h002, 1'b0, 1'b0, ERR_NONE, 3'd0);
        step(1'b1, OP_SEQ, 1'b0, 11'h000, 1'b0);
        chk("seq3", 11'h003, 1'b0, 1'b0, ERR_NONE, 3'd0);

        step(1'b1, OP_JUMP, 1'b0, 11'h7FE, 1'b0);
        chk("jump_7fe", 11'h7FE, 1'b0, 1'b0, ERR_NONE, 3'd0);
        step(1'b1, OP_SEQ, 1'b0, 11'h000, 1'b0);
        chk("seq_7ff", 11'h7FF, 1'b0, 1'b0, ERR_NONE, 3'd0);
        step(1'b1, OP_SEQ, 1'b0, 11'h000, 1'b0);
        chk("seq_wrap", 11'h000, 1'b0, 1'b0, ERR_NONE, 3'd0);

        step(1'b1, OP_JUMP, 1'b0, 11'h010, 1'b0);
        chk("jump_010", 11'h010, 1'b0, 1'b0, ERR_NONE, 3'd0);
        step(1'b1, OP_BRANCH, 1'b0, 11'h100, 1'b0);
        chk("branch_nt", 11'h011, 1'b0, 1'b0, ERR_NONE, 3'd0);
        step(1'b1, OP_BRANCH, 1'b1, 11'h100, 1'b0);
        chk("branch_t", 11'h100, 1'b0, 1'b0, ERR_NONE, 3'd0);
        step(1'b0, OP_JUMP, 1'b1, 11'h555, 1'b0);
        chk("en0_a", 11'h100, 1'b0, 1'b0, ERR_NONE, 3'd0);
        step(1'b0, OP_CALL, 1'b1, 11'h555, 1'b0);
        chk("en0_b", 11'h100, 1'b0, 1'b0, ERR_NONE, 3'd0);

        step(1'b1, OP_JUMP, 1'b0, 11'h020, 1'b0);
        chk("jump_020", 11'h020, 1'b0, 1'b0, ERR_NONE, 3'd0);
        step(1'b1, OP_CALL, 1'b0, 11'h200, 1'b0);
        chk("call1", 11'h200, 1'b0, 1'b0, ERR_NONE, 3'd1);
        step(1'b1, OP_CALL, 1'b0, 11'h300, 1'b0);
        chk("call2", 11'h300, 1'b0, 1'b0, ERR_NONE, 3'd2);
        step(1'b1, OP_CALL, 1'b0, 11'h400, 1'b0);
        chk("call3", 11'h400, 1'b0, 1'b0, ERR_NONE, 3'd3);
        step(1'b1, OP_CALL, 1'b0, 11'h500, 1'b0);
        chk("call4", 11'h500, 1'b0, 1'b0, ERR_NONE, 3'd4);
        step(1'b1, OP_RET, 1'b0, 11'h000, 1'b0);
        chk("ret1", 11'h401, 1'b0, 1'b0, ERR_NONE, 3'd3);
        step(1'b1, OP_RET, 1'b0, 11'h000, 1'b0);
        chk("ret2", 11'h301, 1'b0, 1'b0, ERR_NONE, 3'd2);
        step(1'b1, OP_RET, 1'b0, 11'h000, 1'b0);
        chk("ret3", 11'h201, 1'b0, 1'b0, ERR_NONE, 3'd1);
        step(1'b1, OP_RET, 1'b0, 11'h000, 1'b0);
        chk("ret4", 11'h021, 1'b0, 1'b0, ERR_NONE, 3'd0);

        step(1'b1, OP_CALL, 1'b0, 11'h200, 1'b0);
        step(1'b1, OP_CALL, 1'b0, 11'h300, 1'b0);
        step(1'b1, OP_CALL, 1'b0, 11'h400, 1'b0);
        step(1'b1, OP_CALL, 1'b0, 11'h500, 1'b0);
        chk("refill", 11'h500, 1'b0, 1'b0, ERR_NONE, 3'd4);
        step(1'b1, OP_CALL, 1'b0, 11'h600, 1'b0);
        chk("call_ovf", 11'h500, 1'b0, 1'b1, ERR_OVF, 3'd4);
        step(1'b1, OP_RET, 1'b0, 11'h000, 1'b0);
        chk("ovf_sticky", 11'h500, 1'b0, 1'b1, ERR_OVF, 3'd4);

        async_reset("reset_after_ovf");
        step(1'b1, OP_RET, 1'b0, 11'h000, 1'b0);
        chk("ret_udf", 11'h000, 1'b0, 1'b1, ERR_UDF, 3'd0);

        async_reset("reset_after_udf");
        step(1'b1, OP_JUMP, 1'b0, 11'h050, 1'b0);
        chk("jump_050", 11'h050, 1'b0, 1'b0, ERR_NONE, 3'd0);
        step(1'b1, OP_HALT, 1'b0, 11'h000, 1'b0);
        chk("halt", 11'h050, 1'b1, 1'b0, ERR_NONE, 3'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, OP_JUMP, 1'b1, 11'h123, 1'b0);
            chk($sformatf("halt_hold%0d", i), 11'h050, 1'b1, 1'b0, ERR_NONE, 3'd0);
        end
        step(1'b1, OP_JUMP, 1'b1, 11'h123, 1'b1);
        chk("resume", 11'h051, 1'b0, 1'b0, ERR_NONE, 3'd0);

        step(1'b1, 3'd7, 1'b0, 11'h000, 1'b0);
        chk("illegal7", 11'h051, 1'b0, 1'b1, ERR_ILL, 3'd0);
        step(1'b1, OP_JUMP, 1'b0, 11'h3AA, 1'b1);
        chk("ill_sticky", 11'h051, 1'b0, 1'b1, ERR_ILL, 3'd0);
        async_reset("reset_after_ill");
        chk("after_reset_idle", 11'h000, 1'b0, 1'b0, ERR_NONE, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-address controller for the 11-bit program counter register.
- Decides the following address every step: increment, conditional branch, jump, call with a hardware return-address stack, return, or halt.
- pc_out feeds the PC register's write-data input, which latches on the falling edge. pc_out is registered on the rising edge, so it is stable half a cycle before that write.
- Also emits halt/fault status for the syscall/print path.

Parameters:
- ADDR_W, 11, address width; matches PC3 and PC8 concatenated.
- STACK_DEPTH, 4, number of return-address stack entries (power of 2, 2..16).
- RESET_VECTOR, 11'h000, pc_out value after reset.

Ports:
- CLK  in  1  system clock; all state changes on posedge.
- RST_N  in  1  asynchronous, active-low reset.
- en  in  1  step strobe; when 0 all state holds.
- op  in  3  0=SEQ, 1=BRANCH, 2=JUMP, 3=CALL, 4=RET, 5=HALT, 6/7 illegal.
- cond  in  1  branch condition; sampled only when op=BRANCH.
- target  in  ADDR_W  destination for BRANCH, JUMP and CALL.
- resume  in  1  leaves HALT.
- pc_out  out  ADDR_W  current program address.
- halted  out  1  high while in HALT.
- fault  out  1  high while in FAULT.
- err  out  2  fault cause: 0=none, 1=stack overflow, 2=stack underflow, 3=illegal op.
- depth  out  $clog2(STACK_DEPTH)+1  number of occupied stack entries.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - pc_out=RESET_VECTOR, state=RUN, sp=0, err=0, halted=0, fault=0.
  - Stack contents are don't-care.
- State machine, states RUN, HALT, FAULT; one encoding for all three.
- RUN with en=0: nothing changes.
- RUN with en=1, effect visible on pc_out after one posedge:
  - SEQ: pc_out <= pc_out+1, modulo 2^ADDR_W (0x7FF wraps to 0x000).
  - BRANCH: cond=1 gives pc_out <= target; cond=0 gives pc_out+1.
  - JUMP: pc_out <= target.
  - CALL, sp<STACK_DEPTH: stack[sp] <= pc_out+1 (wrapped), sp++, pc_out <= target.
  - CALL, sp==STACK_DEPTH: go to FAULT with err=1; pc_out, sp and stack unchanged.
  - RET, sp>0: pc_out <= stack[sp-1], sp--.
  - RET, sp==0: go to FAULT with err=2; pc_out unchanged.
  - HALT: go to HALT; pc_out unchanged.
  - op 6 or 7: go to FAULT with err=3; pc_out unchanged.
- HALT state:
  - en and op are ignored.
  - resume=1 on a posedge: back to RUN, pc_out <= pc_out+1.
  - If resume and en are both high, only resume is acted on.
- FAULT state:
  - Sticky; only RST_N exits it.
  - pc_out, sp and err are frozen.
- Status outputs:
  - halted and fault are decoded from registered state; no combinational path from inputs.
- Latency: exactly one cycle from sampled op to new pc_out. No bubbles.
- Stack and depth:
  - One push or pop per cycle at most; no simultaneous push and pop can occur.
  - depth equals sp.
  - A full stack (sp==STACK_DEPTH) remains usable for RET.

Decomposition:
- Shared package holds:
  - op encodings (OP_SEQ … OP_HALT);
  - err codes (ERR_NONE, ERR_OVF, ERR_UDF, ERR_ILL);
  - state encodings;
  - ADDR_W default of 11, shared with the PC register.
- One sub-module: ret_stack.
  - Synchronous LIFO with push, pop, din, dout, full, empty and sp.
  - Reset clears sp only.
  - pc_sequencer instantiates it and owns all fault decisions.

Test Plan:
- Reset then 3 cycles of SEQ with en=1 -> pc_out goes 0x000, 0x001, 0x002, 0x003; err=0.
- JUMP to 0x7FE, then SEQ, SEQ -> pc_out goes 0x7FE, 0x7FF, 0x000 (wrap).
- From pc 0x010, BRANCH cond=0 target 0x100 -> 0x011. Then BRANCH cond=1 target 0x100 -> 0x100. Then en=0 for 2 cycles -> pc_out stays 0x100.
- Nested calls from pc 0x020:
  - CALL 0x200, CALL 0x300, CALL 0x400, CALL 0x500 -> depth=4.
  - RET ×4 -> pc_out goes 0x401, 0x301, 0x201, 0x021; depth=0.
  - A 5th CALL at depth=4 -> fault=1, err=1, pc_out frozen.
  - Separately, RET at depth=0 -> fault=1, err=2.
- HALT at pc 0x050 -> halted=1, pc 0x050 held for 5 cycles with en=1 and op=JUMP. Then resume=1 -> pc 0x051, halted=0.
- op=7 -> fault=1, err=3, with further ops ignored. Assert RST_N=0 between clock edges -> pc_out=0x000, fault=0 immediately, without waiting for a clock edge.
